sweep_tracker: RTL and testbench

SWEEP_TRACKER -- requirements
Module: sweep_tracker

---
 rtl/sweep_tracker.sv | 237 +++++++++++++++++++++++
 tb/tb_sweep_tracker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_tracker.sv
// Raster-sweeps a two-axis servo pair for the peak panel voltage, then parks or hill-climbs around it.
// Outputs are registered and change one CLK after the deciding input; moves wait for TICK, samples wait for ADC_VALID, STOP wins.
module sweep_tracker #(
    parameter int POS_W  = 8,
    parameter int ADC_W  = 12,
    parameter int H_MIN  = 0,
    parameter int H_MAX  = 180,
    parameter int V_MIN  = 0,
    parameter int V_MAX  = 90,
    parameter int STEP   = 1,
    parameter int SETTLE = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             TICK,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic             ADC_VALID,
    input  logic [ADC_W-1:0] ADC_DATA,
    output logic [POS_W-1:0] POS_H,
    output logic [POS_W-1:0] POS_V,
    output logic [ADC_W-1:0] MAX_V,
    output logic [POS_W-1:0] BEST_H,
    output logic [POS_W-1:0] BEST_V,
    output logic             BUSY,
    output logic             DONE,
    output logic [2:0]       STAT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_STEP   = 3'd3,
        S_GOTO   = 3'd4,
        S_TRACK  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // One spare bit so position +/- STEP can be compared against limits without wrapping.
    localparam int XW = POS_W + 1;
    localparam logic [XW-1:0] HMIN_X = XW'(H_MIN);
    localparam logic [XW-1:0] HMAX_X = XW'(H_MAX);
    localparam logic [XW-1:0] VMIN_X = XW'(V_MIN);
    localparam logic [XW-1:0] VMAX_X = XW'(V_MAX);
    localparam logic [XW-1:0] STEP_X = XW'(STEP);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t             r_state;
    logic [POS_W-1:0]   r_pos_h, r_pos_v, r_best_h, r_best_v;
    logic [ADC_W-1:0]   r_max_v;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir_left, r_mode, r_trk, r_ref, r_back;
    logic [1:0]         r_probe;

    logic [XW-1:0] w_h, w_v, w_bh, w_bv, w_h_inc, w_v_inc;
    logic [XW-1:0] w_h_right, w_h_left, w_v_next, w_h_goto, w_v_goto;
    logic          w_h_up_ok, w_h_dn_ok, w_v_up_ok, w_v_dn_ok;
    logic          w_probe_ok, w_at_end, w_at_best, w_better;

    assign w_h       = {1'b0, r_pos_h};
    assign w_v       = {1'b0, r_pos_v};
    assign w_bh      = {1'b0, r_best_h};
    assign w_bv      = {1'b0, r_best_v};
    assign w_h_inc   = w_h + STEP_X;
    assign w_v_inc   = w_v + STEP_X;
    assign w_h_up_ok = (w_h_inc <= HMAX_X);
    assign w_h_dn_ok = (w_h >= HMIN_X + STEP_X);
    assign w_v_up_ok = (w_v_inc <= VMAX_X);
    assign w_v_dn_ok = (w_v >= VMIN_X + STEP_X);
    assign w_h_right = w_h_up_ok ? w_h_inc : HMAX_X;
    assign w_h_left  = w_h_dn_ok ? (w_h - STEP_X) : HMIN_X;
    assign w_v_next  = w_v_up_ok ? w_v_inc : VMAX_X;
    assign w_at_end  = r_dir_left ? (w_h == HMIN_X) : (w_h == HMAX_X);
    assign w_at_best = (r_pos_h == r_best_h) && (r_pos_v == r_best_v);
    assign w_better  = (ADC_DATA > r_max_v);

    // Approach BEST one STEP at a time, landing exactly on it.
    assign w_h_goto = (w_h < w_bh) ? ((w_h_inc > w_bh) ? w_bh : w_h_inc) :
                      (w_h > w_bh) ? ((w_h < w_bh + STEP_X) ? w_bh : (w_h - STEP_X)) : w_h;
    assign w_v_goto = (w_v < w_bv) ? ((w_v_inc > w_bv) ? w_bv : w_v_inc) :
                      (w_v > w_bv) ? ((w_v < w_bv + STEP_X) ? w_bv : (w_v - STEP_X)) : w_v;

    always_comb begin
        w_probe_ok = 1'b0;
        case (r_probe)
            2'd0: w_probe_ok = w_h_up_ok;
            2'd1: w_probe_ok = w_h_dn_ok;
            2'd2: w_probe_ok = w_v_up_ok;
            2'd3: w_probe_ok = w_v_dn_ok;
            default: w_probe_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_pos_h    <= POS_W'(H_MIN);
            r_pos_v    <= POS_W'(V_MIN);
            r_best_h   <= POS_W'(H_MIN);
            r_best_v   <= POS_W'(V_MIN);
            r_max_v    <= '0;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
            r_mode     <= 1'b0;
            r_trk      <= 1'b0;
            r_ref      <= 1'b0;
            r_back     <= 1'b0;
            r_probe    <= 2'd0;
        end else if (STOP) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_mode     <= MODE;
                        r_pos_h    <= POS_W'(H_MIN);
                        r_pos_v    <= POS_W'(V_MIN);
                        r_best_h   <= POS_W'(H_MIN);
                        r_best_v   <= POS_W'(V_MIN);
                        r_max_v    <= '0;
                        r_dir_left <= 1'b0;
                        r_cnt      <= '0;
                        r_trk      <= 1'b0;
                        r_ref      <= 1'b0;
                        r_back     <= 1'b0;
                        r_probe    <= 2'd0;
                        r_state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (SETTLE == 0) begin
                        r_state <= S_SAMPLE;
                    end else if (TICK) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_SAMPLE: begin
                    if (ADC_VALID) begin
                        if (!r_trk) begin
                            if (w_better) begin
                                r_max_v  <= ADC_DATA;
                                r_best_h <= r_pos_h;
                                r_best_v <= r_pos_v;
                            end
                            r_state <= S_STEP;
                        end else if (r_ref || w_better) begin
                            // Reference overwrites unconditionally so the tracker follows a decaying peak.
                            r_max_v  <= ADC_DATA;
                            r_best_h <= r_pos_h;
                            r_best_v <= r_pos_v;
                            r_ref    <= 1'b0;
                            r_back   <= 1'b0;
                            r_probe  <= 2'd0;
                            r_state  <= S_TRACK;
                        end else begin
                            r_back  <= 1'b1;
                            r_state <= S_TRACK;
                        end
                    end
                end
                S_STEP: begin
                    if (TICK) begin
                        if (!w_at_end) begin
                            r_pos_h <= r_dir_left ? w_h_left[POS_W-1:0] : w_h_right[POS_W-1:0];
                            r_cnt   <= '0;
                            r_state <= S_SETTLE;
                        end else if (w_v >= VMAX_X) begin
                            r_state <= S_GOTO;
                        end else begin
                            r_pos_v    <= w_v_next[POS_W-1:0];
                            r_dir_left <= ~r_dir_left;
                            r_cnt      <= '0;
                            r_state    <= S_SETTLE;
                        end
                    end
                end
                S_GOTO: begin
                    if (w_at_best) begin
                        if (r_mode) begin
                            r_trk   <= 1'b1;
                            r_ref   <= 1'b1;
                            r_state <= S_TRACK;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (TICK) begin
                        r_pos_h <= w_h_goto[POS_W-1:0];
                        r_pos_v <= w_v_goto[POS_W-1:0];
                    end
                end
                S_TRACK: begin
                    if (r_ref) begin
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end else if (r_back || !w_probe_ok) begin
                        // A failed probe returns to BEST on TICK; an out-of-range probe is skipped at once.
                        if (!r_back || TICK) begin
                            r_pos_h <= r_best_h;
                            r_pos_v <= r_best_v;
                            r_back  <= 1'b0;
                            r_probe <= r_probe + 2'd1;
                            if (r_probe == 2'd3) r_ref <= 1'b1;
                        end
                    end else if (TICK) begin
                        case (r_probe)
                            2'd0: r_pos_h <= w_h_inc[POS_W-1:0];
                            2'd1: r_pos_h <= w_h_left[POS_W-1:0];
                            2'd2: r_pos_v <= w_v_inc[POS_W-1:0];
                            default: r_pos_v <= w_v[POS_W-1:0] - STEP_X[POS_W-1:0];
                        endcase
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign POS_H  = r_pos_h;
    assign POS_V  = r_pos_v;
    assign MAX_V  = r_max_v;
    assign BEST_H = r_best_h;
    assign BEST_V = r_best_v;
    assign STAT   = r_state;
    assign BUSY   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign DONE   = (r_state == S_DONE);

endmodule

// File: tb/tb_sweep_tracker.sv
// Directed bench for sweep_tracker on a 4x2 grid (H 0..3, V 0..1), STEP=1, SETTLE=2, TICK every 4 CLK.
module tb_sweep_tracker;

    logic        CLK, RST_N, TICK, START, STOP, MODE, ADC_VALID;
    logic [11:0] ADC_DATA, MAX_V;
    logic [3:0]  POS_H, POS_V, BEST_H, BEST_V;
    logic        BUSY, DONE;
    logic [2:0]  STAT;

    int n_total = 0;
    int n_bad   = 0;
    int raster_d [8] = '{5, 9, 3, 2, 4, 7, 12, 6};

    sweep_tracker #(
        .POS_W(4), .ADC_W(12), .H_MIN(0), .H_MAX(3), .V_MIN(0), .V_MAX(1), .STEP(1), .SETTLE(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .TICK(TICK), .START(START), .STOP(STOP), .MODE(MODE),
        .ADC_VALID(ADC_VALID), .ADC_DATA(ADC_DATA), .POS_H(POS_H), .POS_V(POS_V),
        .MAX_V(MAX_V), .BEST_H(BEST_H), .BEST_V(BEST_V), .BUSY(BUSY), .DONE(DONE), .STAT(STAT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        TICK = 1'b0;
        forever begin
            repeat (3) @(posedge CLK);
            #1 TICK = 1'b1;
            @(posedge CLK);
            #1 TICK = 1'b0;
        end
    end

    task automatic wait_stat(input logic [2:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (STAT == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for SAMPLE, records where the servos sit, then delivers one ADC sample.
    task automatic give_sample(input logic [11:0] d, output bit ok,
                               output logic [3:0] ph, output logic [3:0] pv);
        ph = '0;
        pv = '0;
        wait_stat(3'd2, ok);
        if (ok) begin
            ph = POS_H;
            pv = POS_V;
            ADC_DATA  = d;
            ADC_VALID = 1'b1;
            @(negedge CLK);
            ADC_VALID = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic m);
        @(negedge CLK);
        MODE  = m;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; TICK = 1'b0; START = 1'b0; STOP = 1'b0; MODE = 1'b0;
        ADC_VALID = 1'b0; ADC_DATA = '0;
        #12;
        n_total++;
        if (POS_H !== 4'd0 || POS_V !== 4'd0 || BEST_H !== 4'd0 || BEST_V !== 4'd0)
            begin n_bad++; $display("FAIL reset_pos: got pos(%0d,%0d) best(%0d,%0d) want all 0", POS_H, POS_V, BEST_H, BEST_V); end
        n_total++;
        if (MAX_V !== 12'd0 || BUSY !== 1'b0 || DONE !== 1'b0 || STAT !== 3'd0)
            begin n_bad++; $display("FAIL reset_flags: got max=%0d busy=%0d done=%0d stat=%0d want 0/0/0/0", MAX_V, BUSY, DONE, STAT); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        ADC_DATA = 12'd77; ADC_VALID = 1'b1;
        @(negedge CLK);
        ADC_VALID = 1'b0;
        repeat (6) @(negedge CLK);
        n_total++;
        if (STAT !== 3'd0 || MAX_V !== 12'd0)
            begin n_bad++; $display("FAIL idle_before_start: got stat=%0d max=%0d want 0/0", STAT, MAX_V); end
    endtask

    task automatic test_raster();
        bit ok;
        logic [3:0] ph, pv, eh, ev;
        pulse_start(1'b0);
        n_total++;
        if (BUSY !== 1'b1 || STAT !== 3'd1)
            begin n_bad++; $display("FAIL raster_start: got busy=%0d stat=%0d want 1/1", BUSY, STAT); end
        for (int i = 0; i < 8; i++) begin
            eh = (i < 4) ? 4'(i) : 4'(7 - i);
            ev = (i < 4) ? 4'd0 : 4'd1;
            give_sample(12'(raster_d[i]), ok, ph, pv);
            n_total++;
            if (!ok || ph !== eh || pv !== ev)
                begin n_bad++; $display("FAIL raster_pos[%0d]: got (%0d,%0d) ok=%0d want (%0d,%0d)", i, ph, pv, ok, eh, ev); end
            if (i == 1) begin
                n_total++;
                if (MAX_V !== 12'd9 || BEST_H !== 4'd1 || BEST_V !== 4'd0)
                    begin n_bad++; $display("FAIL raster_mid_best: got max=%0d best(%0d,%0d) want 9 (1,0)", MAX_V, BEST_H, BEST_V); end
            end
        end
        wait_stat(3'd6, ok);
        n_total++;
        if (!ok) begin n_bad++; $display("FAIL raster_done_timeout: got stat=%0d want 6", STAT); end
        n_total++;
        if (MAX_V !== 12'd12 || BEST_H !== 4'd1 || BEST_V !== 4'd1)
            begin n_bad++; $display("FAIL raster_best: got max=%0d best(%0d,%0d) want 12 (1,1)", MAX_V, BEST_H, BEST_V); end
        n_total++;
        if (POS_H !== 4'd1 || POS_V !== 4'd1 || DONE !== 1'b1 || BUSY !== 1'b0)
            begin n_bad++; $display("FAIL raster_park: got pos(%0d,%0d) done=%0d busy=%0d want (1,1) 1 0", POS_H, POS_V, DONE, BUSY); end
    endtask

    task automatic test_equal();
        bit ok, all_ok;
        logic [3:0] ph, pv;
        all_ok = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            give_sample(12'd8, ok, ph, pv);
            all_ok = all_ok & ok;
        end
        wait_stat(3'd6, ok);
        n_total++;
        if (!(ok && all_ok)) begin n_bad++; $display("FAIL equal_timeout: got stat=%0d want 6", STAT); end
        n_total++;
        if (MAX_V !== 12'd8 || BEST_H !== 4'd0 || BEST_V !== 4'd0 || POS_H !== 4'd0 || POS_V !== 4'd0)
            begin n_bad++; $display("FAIL equal_keep_first: got max=%0d best(%0d,%0d) pos(%0d,%0d) want 8 (0,0) (0,0)", MAX_V, BEST_H, BEST_V, POS_H, POS_V); end
    endtask

    task automatic test_track();
        bit ok;
        logic [3:0] ph, pv;
        logic [11:0] td [11] = '{10, 11, 9, 5, 3, 10, 20, 1, 1, 0, 0};
        logic [3:0]  th [10] = '{1, 2, 3, 1, 2, 2, 3, 2, 3, 3};
        logic [3:0]  tv [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1};
        pulse_start(1'b1);
        for (int i = 0; i < 8; i++) give_sample(12'(raster_d[i]), ok, ph, pv);
        wait_stat(3'd5, ok);
        n_total++;
        if (!ok || POS_H !== 4'd1 || POS_V !== 4'd1)
            begin n_bad++; $display("FAIL track_enter: got stat=%0d pos(%0d,%0d) want 5 (1,1)", STAT, POS_H, POS_V); end
        for (int i = 0; i < 9; i++) begin
            give_sample(td[i], ok, ph, pv);
            n_total++;
            if (!ok || ph !== th[i] || pv !== tv[i])
                begin n_bad++; $display("FAIL track_pos[%0d]: got (%0d,%0d) ok=%0d want (%0d,%0d)", i, ph, pv, ok, th[i], tv[i]); end
            if (i == 1) begin
                n_total++;
                if (MAX_V !== 12'd11 || BEST_H !== 4'd2 || BEST_V !== 4'd1)
                    begin n_bad++; $display("FAIL track_accept: got max=%0d best(%0d,%0d) want 11 (2,1)", MAX_V, BEST_H, BEST_V); end
            end
            if (i == 2) begin
                ok = 1'b0;
                for (int k = 0; k < 40; k++) begin
                    @(negedge CLK);
                    if (POS_H == 4'd2) begin ok = 1'b1; break; end
                end
                n_total++;
                if (!ok || POS_V !== 4'd1 || BEST_H !== 4'd2 || MAX_V !== 12'd11)
                    begin n_bad++; $display("FAIL track_return: got pos(%0d,%0d) best_h=%0d max=%0d want (2,1) 2 11", POS_H, POS_V, BEST_H, MAX_V); end
            end
            if (i == 5) begin
                n_total++;
                if (MAX_V !== 12'd10)
                    begin n_bad++; $display("FAIL track_decay: got max=%0d want 10", MAX_V); end
            end
        end
        // Reference sample at (3,1) is pending; STOP must beat the coincident ADC_VALID.
        wait_stat(3'd2, ok);
        n_total++;
        if (!ok || POS_H !== 4'd3 || POS_V !== 4'd1)
            begin n_bad++; $display("FAIL track_ref_pos: got (%0d,%0d) ok=%0d want (3,1)", POS_H, POS_V, ok); end
        STOP = 1'b1; ADC_VALID = 1'b1; ADC_DATA = 12'd50;
        @(negedge CLK);
        STOP = 1'b0; ADC_VALID = 1'b0;
        n_total++;
        if (STAT !== 3'd0 || MAX_V !== 12'd20 || BEST_H !== 4'd3 || POS_H !== 4'd3 || POS_V !== 4'd1)
            begin n_bad++; $display("FAIL track_stop: got stat=%0d max=%0d best_h=%0d pos(%0d,%0d) want 0 20 3 (3,1)", STAT, MAX_V, BEST_H, POS_H, POS_V); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [3:0] ph, pv;
        pulse_start(1'b0);
        give_sample(12'd5, ok, ph, pv);
        give_sample(12'd9, ok, ph, pv);
        wait_stat(3'd2, ok);
        n_total++;
        if (!ok || POS_H !== 4'd2 || POS_V !== 4'd0)
            begin n_bad++; $display("FAIL rst_mid_pos: got (%0d,%0d) ok=%0d want (2,0)", POS_H, POS_V, ok); end
        RST_N = 1'b0;
        #1;
        n_total++;
        if (POS_H !== 4'd0 || POS_V !== 4'd0 || MAX_V !== 12'd0 || BUSY !== 1'b0 || STAT !== 3'd0)
            begin n_bad++; $display("FAIL rst_mid_async: got pos(%0d,%0d) max=%0d busy=%0d stat=%0d want (0,0) 0 0 0", POS_H, POS_V, MAX_V, BUSY, STAT); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        ADC_DATA = 12'd100; ADC_VALID = 1'b1;
        @(negedge CLK);
        ADC_VALID = 1'b0;
        repeat (8) @(negedge CLK);
        n_total++;
        if (MAX_V !== 12'd0 || STAT !== 3'd0)
            begin n_bad++; $display("FAIL rst_mid_ignore_adc: got max=%0d stat=%0d want 0 0", MAX_V, STAT); end
    endtask

    task automatic test_stop();
        bit ok;
        logic [3:0] ph, pv;
        @(negedge CLK);
        START = 1'b1; STOP = 1'b1; MODE = 1'b0;
        @(negedge CLK);
        START = 1'b0; STOP = 1'b0;
        repeat (3) @(negedge CLK);
        n_total++;
        if (STAT !== 3'd0 || BUSY !== 1'b0)
            begin n_bad++; $display("FAIL stop_vs_start: got stat=%0d busy=%0d want 0 0", STAT, BUSY); end
        pulse_start(1'b0);
        give_sample(12'd7, ok, ph, pv);
        wait_stat(3'd1, ok);
        n_total++;
        if (!ok || POS_H !== 4'd1)
            begin n_bad++; $display("FAIL stop_reach_settle: got stat=%0d pos_h=%0d want 1 1", STAT, POS_H); end
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        n_total++;
        if (STAT !== 3'd0 || POS_H !== 4'd1 || POS_V !== 4'd0 || MAX_V !== 12'd7)
            begin n_bad++; $display("FAIL stop_in_settle: got stat=%0d pos(%0d,%0d) max=%0d want 0 (1,0) 7", STAT, POS_H, POS_V, MAX_V); end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_equal();
        test_track();
        test_reset_mid();
        test_stop();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
